// File: rtl/buff_uart_pkg.sv
// ----------------------------------------------------------------------------
// buff_uart_pkg : shared types for the buffered UART bus host
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package buff_uart_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } bus_dir_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } host_state_t;

endpackage

`default_nettype wire

// File: rtl/buff_uart_host.sv
// ----------------------------------------------------------------------------
// buff_uart_host : single-outstanding request/response host driving a simple
// strobed peripheral bus (setup, one-cycle strobe, fixed read latency).
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module buff_uart_host
  import buff_uart_pkg::*;
#(
  parameter int width         = 8,
  parameter int address_width = 4,
  parameter int read_latency  = 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  bus_dir_t                 req_dir,
  input  logic [address_width-1:0] req_address,
  input  logic [width-1:0]         req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [width-1:0]         rsp_rdata,
  output logic [address_width-1:0] active_address,
  output logic                     write_enable,
  output logic                     read_enable,
  output logic [width-1:0]         data_out,
  input  logic [width-1:0]         data_in
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(read_latency);

  host_state_t              state_q, state_d;
  bus_dir_t                 dir_q;
  logic [address_width-1:0] addr_q;
  logic [width-1:0]         wdata_q;
  logic [width-1:0]         rdata_q, rdata_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     init_q;
  logic                     accept;

  // init_q keeps req_ready low while in reset and for the edge it is released on
  assign req_ready      = init_q && (state_q == IDLE);
  assign accept         = req_valid && req_ready;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_rdata      = rdata_q;
  assign active_address = addr_q;
  assign data_out       = wdata_q;
  assign write_enable   = (state_q == STROBE) && (dir_q == WRITE);
  assign read_enable    = (state_q == STROBE) && (dir_q == READ);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
      end
      STROBE: begin
        if (dir_q == WRITE) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT;
        end
      end
      WAIT: begin
        // a count of one marks the final wait cycle, when data_in is valid
        if (cnt_q <= CNT_W'(1)) begin
          rdata_d = data_in;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      init_q  <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dir_q   <= READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      dir_q   <= req_dir;
      addr_q  <= req_address;
      wdata_q <= req_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_buff_uart_host.sv
// ----------------------------------------------------------------------------
// tb_buff_uart_host : directed self-checking bench, one instance per latency.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_buff_uart_host;
  import buff_uart_pkg::*;

  logic       clock = 1'b0;
  logic       resetn;
  bus_dir_t   req_dir;
  logic [3:0] req_address;
  logic [7:0] req_wdata;
  logic [7:0] data_in;

  logic       req_valid1, rsp_ready1, req_ready1, rsp_valid1, we1, re1;
  logic [7:0] rsp_rdata1, data_out1;
  logic [3:0] addr1;

  logic       req_valid3, rsp_ready3, req_ready3, rsp_valid3, we3, re3;
  logic [7:0] rsp_rdata3, data_out3;
  logic [3:0] addr3;

  int n_tests = 0;
  int n_fail  = 0;
  logic overlap_seen = 1'b0;

  always #5 clock = ~clock;

  buff_uart_host #(.width(8), .address_width(4), .read_latency(1)) dut1 (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_dir(req_dir),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1),
    .active_address(addr1), .write_enable(we1), .read_enable(re1),
    .data_out(data_out1), .data_in(data_in)
  );

  buff_uart_host #(.width(8), .address_width(4), .read_latency(3)) dut3 (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_dir(req_dir),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .active_address(addr3), .write_enable(we3), .read_enable(re3),
    .data_out(data_out3), .data_in(data_in)
  );

  always @(negedge clock) begin
    if ((we1 && re1) || (we3 && re3)) overlap_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready1), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid1), 32'd0);
    check({tag, "_we"},        32'(we1),        32'd0);
    check({tag, "_re"},        32'(re1),        32'd0);
    check({tag, "_addr"},      32'(addr1),      32'd0);
    check({tag, "_data_out"},  32'(data_out1),  32'd0);
    check({tag, "_rdata"},     32'(rsp_rdata1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    req_dir = READ; req_address = '0; req_wdata = '0; data_in = '0;
    req_valid1 = 0; rsp_ready1 = 0; req_valid3 = 0; rsp_ready3 = 0;

    // Reset state and release
    #12;
    check_reset_outputs("rst");
    check("rst_req_ready3", 32'(req_ready3), 32'd0);
    #4 resetn = 1'b1;
    #1 check("rel_ready_low", 32'(req_ready1), 32'd0);
    step();
    check("rel_ready_high", 32'(req_ready1), 32'd1);

    // WRITE addr 2 data A5
    req_valid1 = 1; req_dir = WRITE; req_address = 4'h2; req_wdata = 8'hA5;
    step();
    req_valid1 = 0;
    check("wr_setup_ready", 32'(req_ready1), 32'd0);
    check("wr_setup_we",    32'(we1),        32'd0);
    check("wr_setup_re",    32'(re1),        32'd0);
    check("wr_setup_addr",  32'(addr1),      32'h2);
    check("wr_setup_data",  32'(data_out1),  32'hA5);
    step();
    check("wr_strobe_we",   32'(we1),        32'd1);
    check("wr_strobe_re",   32'(re1),        32'd0);
    check("wr_strobe_addr", 32'(addr1),      32'h2);
    check("wr_strobe_data", 32'(data_out1),  32'hA5);
    step();
    check("wr_idle_ready",  32'(req_ready1), 32'd1);
    check("wr_idle_we",     32'(we1),        32'd0);
    check("wr_idle_hold_a", 32'(addr1),      32'h2);
    check("wr_idle_hold_d", 32'(data_out1),  32'hA5);
    check("wr_no_rsp",      32'(rsp_valid1), 32'd0);

    // READ addr 3, latency 1; early rsp_ready must be ignored before RESP
    req_valid1 = 1; req_dir = READ; req_address = 4'h3; data_in = 8'h5C;
    step();
    req_valid1 = 0; rsp_ready1 = 1;
    check("rd1_setup_re", 32'(re1), 32'd0);
    step();
    check("rd1_strobe_re",   32'(re1),   32'd1);
    check("rd1_strobe_we",   32'(we1),   32'd0);
    check("rd1_strobe_addr", 32'(addr1), 32'h3);
    step();
    check("rd1_wait_re",    32'(re1),        32'd0);
    check("rd1_wait_valid", 32'(rsp_valid1), 32'd0);
    step();
    check("rd1_resp_valid", 32'(rsp_valid1), 32'd1);
    check("rd1_resp_rdata", 32'(rsp_rdata1), 32'h5C);
    step();
    check("rd1_done_valid", 32'(rsp_valid1), 32'd0);
    check("rd1_done_ready", 32'(req_ready1), 32'd1);

    // READ addr 7 on latency-3 instance with stalled consumer
    req_valid3 = 1; req_dir = READ; req_address = 4'h7; data_in = 8'hC3;
    step();
    req_address = 4'h9;
    step();
    check("rd3_strobe_re",   32'(re3),   32'd1);
    check("rd3_strobe_addr", 32'(addr3), 32'h7);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rd3_wait%0d_valid", i), 32'(rsp_valid3), 32'd0);
    end
    step();
    data_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rd3_stall%0d_valid", i), 32'(rsp_valid3), 32'd1);
      check($sformatf("rd3_stall%0d_rdata", i), 32'(rsp_rdata3), 32'hC3);
      check($sformatf("rd3_stall%0d_ready", i), 32'(req_ready3), 32'd0);
      if (i < 4) step();
    end
    rsp_ready3 = 1; req_valid3 = 0;
    step();
    rsp_ready3 = 0;
    check("rd3_idle_valid", 32'(rsp_valid3), 32'd0);
    check("rd3_idle_ready", 32'(req_ready3), 32'd1);

    // Back-to-back WRITE, READ, WRITE with req_valid held high
    req_valid1 = 1; req_dir = WRITE; req_address = 4'h1; req_wdata = 8'h11;
    step();
    req_dir = READ; req_address = 4'h4; req_wdata = 8'hEE; data_in = 8'h9E;
    check("b2b_w1_ready", 32'(req_ready1), 32'd0);
    step();
    check("b2b_w1_we",   32'(we1),       32'd1);
    check("b2b_w1_addr", 32'(addr1),     32'h1);
    check("b2b_w1_data", 32'(data_out1), 32'h11);
    step();
    check("b2b_idle1_ready", 32'(req_ready1), 32'd1);
    step();
    check("b2b_r_setup_addr", 32'(addr1), 32'h4);
    req_dir = WRITE; req_address = 4'h5; req_wdata = 8'h55;
    step();
    check("b2b_r_re", 32'(re1), 32'd1);
    check("b2b_r_we", 32'(we1), 32'd0);
    step();
    check("b2b_r_wait_ready", 32'(req_ready1), 32'd0);
    step();
    check("b2b_r_rdata", 32'(rsp_rdata1), 32'h9E);
    check("b2b_r_valid", 32'(rsp_valid1), 32'd1);
    step();
    check("b2b_idle2_ready", 32'(req_ready1), 32'd1);
    step();
    req_valid1 = 0;
    check("b2b_w2_addr", 32'(addr1),     32'h5);
    check("b2b_w2_data", 32'(data_out1), 32'h55);
    step();
    check("b2b_w2_we", 32'(we1), 32'd1);
    check("b2b_w2_re", 32'(re1), 32'd0);
    step();
    check("b2b_idle3_ready", 32'(req_ready1), 32'd1);
    check("no_strobe_overlap", 32'(overlap_seen), 32'd0);

    // Reset during the STROBE cycle of a READ
    req_valid1 = 1; req_dir = READ; req_address = 4'h6;
    step();
    req_valid1 = 0;
    step();
    check("rst_mid_re_before", 32'(re1), 32'd1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("rst_mid");
    step();
    step();
    check_reset_outputs("rst_hold");
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_rst%0d_valid", i), 32'(rsp_valid1), 32'd0);
      check($sformatf("post_rst%0d_re", i),    32'(re1),        32'd0);
    end
    check("post_rst_ready", 32'(req_ready1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
